// File: rtl/l1d_linefill_rsp_ctrl_pkg.sv
// ============================================================================
// l1d_package : shared L1D linefill constants, transfer structs and FSM state
// Rev 1.0
// ============================================================================
`default_nettype none

package l1d_package;

  localparam int L1D_MSHR_ENTRY_NUM = 8;
  localparam int L1D_LINE_BEATS     = 4;
  localparam int L1D_BEAT_WIDTH     = 128;
  localparam int L1D_MSHR_ID_W      = $clog2(L1D_MSHR_ENTRY_NUM);
  localparam int L1D_LINE_WIDTH     = L1D_LINE_BEATS * L1D_BEAT_WIDTH;

  typedef struct packed {
    logic [L1D_MSHR_ID_W-1:0]  id;
    logic [L1D_BEAT_WIDTH-1:0] data;
    logic                      last;
  } pack_l1d_linefill_rsp;

  typedef struct packed {
    logic [L1D_MSHR_ID_W-1:0]  id;
    logic [L1D_LINE_WIDTH-1:0] data;
  } pack_l1d_dat_ram_wr;

  typedef enum logic [0:0] {
    LF_COLLECT = 1'b0,
    LF_WRITE   = 1'b1
  } l1d_lf_state_e;

endpackage

`default_nettype wire

// File: rtl/l1d_linefill_buf.sv
// ============================================================================
// l1d_linefill_buf : beat-indexed single-line register, flat line output
// Rev 1.0
// ============================================================================
`default_nettype none

module l1d_linefill_buf #(
  parameter int BEATS  = 4,
  parameter int BEAT_W = 128
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en_i,
  input  logic [$clog2(BEATS)-1:0]   wr_slot_i,
  input  logic [BEAT_W-1:0]          wr_data_i,
  output logic [BEATS*BEAT_W-1:0]    line_o
);

  logic [BEATS-1:0][BEAT_W-1:0] slot_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else if (wr_en_i) begin
      slot_q[wr_slot_i] <= wr_data_i;
    end
  end

  // Slot 0 lands in the LSBs of the flat line.
  assign line_o = slot_q;

endmodule

`default_nettype wire

// File: rtl/l1d_linefill_rsp_ctrl.sv
// ============================================================================
// l1d_linefill_rsp_ctrl : assembles multi-beat linefill responses and writes
// full lines to the L1D data RAM, then pulses the owning MSHR entry.  Rev 1.0
// ============================================================================
`default_nettype none

module l1d_linefill_rsp_ctrl #(
  parameter  int L1D_MSHR_ENTRY_NUM = l1d_package::L1D_MSHR_ENTRY_NUM,
  parameter  int L1D_LINE_BEATS     = l1d_package::L1D_LINE_BEATS,
  parameter  int L1D_BEAT_WIDTH     = l1d_package::L1D_BEAT_WIDTH,
  localparam int ID_W               = $clog2(L1D_MSHR_ENTRY_NUM)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     rsp_vld,
  output logic                                     rsp_rdy,
  input  logic [ID_W-1:0]                          rsp_id,
  input  logic [L1D_BEAT_WIDTH-1:0]                rsp_data,
  input  logic                                     rsp_last,
  output logic                                     dat_ram_wr_vld,
  input  logic                                     dat_ram_wr_rdy,
  output logic [ID_W-1:0]                          dat_ram_wr_id,
  output logic [L1D_LINE_BEATS*L1D_BEAT_WIDTH-1:0] dat_ram_wr_data,
  output logic [L1D_MSHR_ENTRY_NUM-1:0]            linefill_done_en,
  output logic                                     proto_err
);

  import l1d_package::*;

  localparam int               CNT_W     = $clog2(L1D_LINE_BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(L1D_LINE_BEATS - 1);

  l1d_lf_state_e                 state_q, state_d;
  logic [CNT_W-1:0]              beat_cnt_q, beat_cnt_d;
  logic [ID_W-1:0]               cur_id_q, cur_id_d;
  logic [L1D_MSHR_ENTRY_NUM-1:0] done_q, done_d;
  logic                          proto_err_q, proto_err_d;

  logic beat_acc;
  logic last_slot;
  logic beat_err;

  assign rsp_rdy        = (state_q == LF_COLLECT);
  assign dat_ram_wr_vld = (state_q == LF_WRITE);
  assign beat_acc       = rsp_vld & rsp_rdy;
  assign last_slot      = (beat_cnt_q == LAST_BEAT);

  // rsp_last is advisory: it must agree with the count, but only the count ends a line.
  assign beat_err = (rsp_last != last_slot) |
                    ((beat_cnt_q != '0) & (rsp_id != cur_id_q));

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    cur_id_d    = cur_id_q;
    done_d      = '0;
    proto_err_d = proto_err_q;
    case (state_q)
      LF_COLLECT: begin
        if (beat_acc) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == '0) begin
            cur_id_d = rsp_id;
          end
          if (beat_err) begin
            proto_err_d = 1'b1;
          end
          if (last_slot) begin
            state_d = LF_WRITE;
          end
        end
      end
      LF_WRITE: begin
        if (dat_ram_wr_rdy) begin
          state_d          = LF_COLLECT;
          done_d[cur_id_q] = 1'b1;
        end
      end
      default: begin
        state_d = LF_COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LF_COLLECT;
      beat_cnt_q  <= '0;
      cur_id_q    <= '0;
      done_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      cur_id_q    <= cur_id_d;
      done_q      <= done_d;
      proto_err_q <= proto_err_d;
    end
  end

  l1d_linefill_buf #(
    .BEATS  (L1D_LINE_BEATS),
    .BEAT_W (L1D_BEAT_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (beat_acc),
    .wr_slot_i (beat_cnt_q),
    .wr_data_i (rsp_data),
    .line_o    (dat_ram_wr_data)
  );

  assign dat_ram_wr_id    = cur_id_q;
  assign linefill_done_en = done_q;
  assign proto_err        = proto_err_q;

endmodule

`default_nettype wire

// File: tb/tb_l1d_linefill_rsp_ctrl.sv
// ============================================================================
// tb_l1d_linefill_rsp_ctrl : directed self-checking bench for the linefill
// response controller.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_l1d_linefill_rsp_ctrl;

  localparam int N     = 8;
  localparam int BEATS = 4;
  localparam int BW    = 128;
  localparam int IDW   = 3;
  localparam int LW    = BEATS * BW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           rsp_vld = 1'b0;
  logic           rsp_rdy;
  logic [IDW-1:0] rsp_id = '0;
  logic [BW-1:0]  rsp_data = '0;
  logic           rsp_last = 1'b0;
  logic           dat_ram_wr_vld;
  logic           dat_ram_wr_rdy = 1'b0;
  logic [IDW-1:0] dat_ram_wr_id;
  logic [LW-1:0]  dat_ram_wr_data;
  logic [N-1:0]   linefill_done_en;
  logic           proto_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  l1d_linefill_rsp_ctrl #(
    .L1D_MSHR_ENTRY_NUM (N),
    .L1D_LINE_BEATS     (BEATS),
    .L1D_BEAT_WIDTH     (BW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rsp_vld          (rsp_vld),
    .rsp_rdy          (rsp_rdy),
    .rsp_id           (rsp_id),
    .rsp_data         (rsp_data),
    .rsp_last         (rsp_last),
    .dat_ram_wr_vld   (dat_ram_wr_vld),
    .dat_ram_wr_rdy   (dat_ram_wr_rdy),
    .dat_ram_wr_id    (dat_ram_wr_id),
    .dat_ram_wr_data  (dat_ram_wr_data),
    .linefill_done_en (linefill_done_en),
    .proto_err        (proto_err)
  );

  function automatic logic [BW-1:0] mk_beat(input logic [7:0] tag, input int i);
    logic [7:0] idx;
    idx = 8'(i);
    return {4{tag, idx, 16'hC0DE ^ {idx, idx}}};
  endfunction

  function automatic logic [LW-1:0] mk_line(input logic [7:0] tag);
    return {mk_beat(tag, 3), mk_beat(tag, 2), mk_beat(tag, 1), mk_beat(tag, 0)};
  endfunction

  // Presents one beat and returns on the negedge after it has been taken.
  task automatic send_beat(input logic [IDW-1:0] id, input logic [BW-1:0] d, input logic last);
    int n;
    n = 0;
    rsp_vld  = 1'b1;
    rsp_id   = id;
    rsp_data = d;
    rsp_last = last;
    while (rsp_rdy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++; failures++;
      $display("FAIL beat_accept_timeout act=rsp_rdy_low_20_cycles exp=accepted");
    end
    @(negedge clk);
    rsp_vld  = 1'b0;
    rsp_last = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (rsp_rdy !== 1'b1) begin failures++; $display("FAIL reset_rsp_rdy act=%b exp=1", rsp_rdy); end
    checks++; if (dat_ram_wr_vld !== 1'b0) begin failures++; $display("FAIL reset_wr_vld act=%b exp=0", dat_ram_wr_vld); end
    checks++; if (dat_ram_wr_id !== '0) begin failures++; $display("FAIL reset_wr_id act=%0d exp=0", dat_ram_wr_id); end
    checks++; if (dat_ram_wr_data !== '0) begin failures++; $display("FAIL reset_wr_data act=%h exp=0", dat_ram_wr_data); end
    checks++; if (linefill_done_en !== '0) begin failures++; $display("FAIL reset_done act=%b exp=0", linefill_done_en); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL reset_proto_err act=%b exp=0", proto_err); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_line();
    dat_ram_wr_rdy = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(3'd3, mk_beat(8'hA0, i), i == 3);
    checks++; if (dat_ram_wr_vld !== 1'b1) begin failures++; $display("FAIL single_wr_vld act=%b exp=1", dat_ram_wr_vld); end
    checks++; if (dat_ram_wr_id !== 3'd3) begin failures++; $display("FAIL single_wr_id act=%0d exp=3", dat_ram_wr_id); end
    checks++; if (dat_ram_wr_data !== mk_line(8'hA0)) begin failures++; $display("FAIL single_wr_data act=%h exp=%h", dat_ram_wr_data, mk_line(8'hA0)); end
    checks++; if (rsp_rdy !== 1'b0) begin failures++; $display("FAIL single_rsp_rdy_write act=%b exp=0", rsp_rdy); end
    checks++; if (linefill_done_en !== 8'b0) begin failures++; $display("FAIL single_done_early act=%b exp=0", linefill_done_en); end
    @(negedge clk);
    checks++; if (linefill_done_en !== 8'b0000_1000) begin failures++; $display("FAIL single_done act=%b exp=00001000", linefill_done_en); end
    checks++; if (rsp_rdy !== 1'b1) begin failures++; $display("FAIL single_rsp_rdy_pulse act=%b exp=1", rsp_rdy); end
    checks++; if (dat_ram_wr_vld !== 1'b0) begin failures++; $display("FAIL single_wr_vld_after act=%b exp=0", dat_ram_wr_vld); end
    @(negedge clk);
    checks++; if (linefill_done_en !== 8'b0) begin failures++; $display("FAIL single_done_width act=%b exp=0", linefill_done_en); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL single_proto_err act=%b exp=0", proto_err); end
  endtask

  task automatic test_backpressure();
    dat_ram_wr_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(3'd4, mk_beat(8'hB0, i), i == 3);
    // A stray beat is offered while the write is stalled; it must not be taken.
    rsp_vld  = 1'b1;
    rsp_id   = 3'd7;
    rsp_data = mk_beat(8'hEE, 0);
    rsp_last = 1'b0;
    for (int c = 0; c < 6; c++) begin
      checks++; if (dat_ram_wr_vld !== 1'b1) begin failures++; $display("FAIL bp_wr_vld c=%0d act=%b exp=1", c, dat_ram_wr_vld); end
      checks++; if (dat_ram_wr_id !== 3'd4) begin failures++; $display("FAIL bp_wr_id c=%0d act=%0d exp=4", c, dat_ram_wr_id); end
      checks++; if (dat_ram_wr_data !== mk_line(8'hB0)) begin failures++; $display("FAIL bp_wr_data c=%0d act=%h exp=%h", c, dat_ram_wr_data, mk_line(8'hB0)); end
      checks++; if (rsp_rdy !== 1'b0) begin failures++; $display("FAIL bp_rsp_rdy c=%0d act=%b exp=0", c, rsp_rdy); end
      checks++; if (linefill_done_en !== 8'b0) begin failures++; $display("FAIL bp_done_early c=%0d act=%b exp=0", c, linefill_done_en); end
      if (c == 5) dat_ram_wr_rdy = 1'b1;
      @(negedge clk);
    end
    rsp_vld = 1'b0;
    checks++; if (linefill_done_en !== 8'b0001_0000) begin failures++; $display("FAIL bp_done act=%b exp=00010000", linefill_done_en); end
    @(negedge clk);
    checks++; if (linefill_done_en !== 8'b0) begin failures++; $display("FAIL bp_done_width act=%b exp=0", linefill_done_en); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL bp_proto_err act=%b exp=0", proto_err); end
  endtask

  task automatic test_back_to_back();
    int            pulse_cyc[$];
    logic [N-1:0]  pulse_val[$];
    logic [LW-1:0] wr_seen[$];
    dat_ram_wr_rdy = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++) send_beat(3'd1, mk_beat(8'hC0, i), i == 3);
        for (int i = 0; i < 4; i++) send_beat(3'd6, mk_beat(8'hD0, i), i == 3);
      end
      begin
        for (int c = 0; c < 16; c++) begin
          @(negedge clk);
          if (linefill_done_en !== 8'b0) begin
            pulse_cyc.push_back(c);
            pulse_val.push_back(linefill_done_en);
          end
          if (dat_ram_wr_vld === 1'b1) wr_seen.push_back(dat_ram_wr_data);
        end
      end
    join
    checks++; if (pulse_cyc.size() != 2) begin failures++; $display("FAIL b2b_pulse_count act=%0d exp=2", pulse_cyc.size()); end
    if (pulse_cyc.size() == 2) begin
      checks++; if (pulse_val[0] !== 8'b0000_0010) begin failures++; $display("FAIL b2b_pulse0 act=%b exp=00000010", pulse_val[0]); end
      checks++; if (pulse_val[1] !== 8'b0100_0000) begin failures++; $display("FAIL b2b_pulse1 act=%b exp=01000000", pulse_val[1]); end
      checks++; if (pulse_cyc[1] - pulse_cyc[0] != 5) begin failures++; $display("FAIL b2b_pulse_gap act=%0d exp=5", pulse_cyc[1] - pulse_cyc[0]); end
    end
    checks++; if (wr_seen.size() != 2) begin failures++; $display("FAIL b2b_write_count act=%0d exp=2", wr_seen.size()); end
    if (wr_seen.size() == 2) begin
      checks++; if (wr_seen[0] !== mk_line(8'hC0)) begin failures++; $display("FAIL b2b_line0 act=%h exp=%h", wr_seen[0], mk_line(8'hC0)); end
      checks++; if (wr_seen[1] !== mk_line(8'hD0)) begin failures++; $display("FAIL b2b_line1 act=%h exp=%h", wr_seen[1], mk_line(8'hD0)); end
    end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL b2b_proto_err act=%b exp=0", proto_err); end
  endtask

  task automatic test_early_last();
    dat_ram_wr_rdy = 1'b1;
    send_beat(3'd5, mk_beat(8'hE0, 0), 1'b0);
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL early_err_before act=%b exp=0", proto_err); end
    send_beat(3'd5, mk_beat(8'hE0, 1), 1'b1);
    checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL early_err_set act=%b exp=1", proto_err); end
    send_beat(3'd5, mk_beat(8'hE0, 2), 1'b0);
    checks++; if (dat_ram_wr_vld !== 1'b0) begin failures++; $display("FAIL early_no_stop act=%b exp=0", dat_ram_wr_vld); end
    send_beat(3'd5, mk_beat(8'hE0, 3), 1'b1);
    checks++; if (dat_ram_wr_vld !== 1'b1) begin failures++; $display("FAIL early_wr_vld act=%b exp=1", dat_ram_wr_vld); end
    checks++; if (dat_ram_wr_data !== mk_line(8'hE0)) begin failures++; $display("FAIL early_wr_data act=%h exp=%h", dat_ram_wr_data, mk_line(8'hE0)); end
    @(negedge clk);
    checks++; if (linefill_done_en !== 8'b0010_0000) begin failures++; $display("FAIL early_done act=%b exp=00100000", linefill_done_en); end
  endtask

  task automatic test_id_change();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dat_ram_wr_rdy = 1'b1;
    @(negedge clk);
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL idchg_err_cleared act=%b exp=0", proto_err); end
    send_beat(3'd2, mk_beat(8'hF0, 0), 1'b0);
    send_beat(3'd2, mk_beat(8'hF0, 1), 1'b0);
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL idchg_err_before act=%b exp=0", proto_err); end
    send_beat(3'd5, mk_beat(8'hF0, 2), 1'b0);
    checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL idchg_err_set act=%b exp=1", proto_err); end
    send_beat(3'd2, mk_beat(8'hF0, 3), 1'b1);
    checks++; if (dat_ram_wr_id !== 3'd2) begin failures++; $display("FAIL idchg_wr_id act=%0d exp=2", dat_ram_wr_id); end
    checks++; if (dat_ram_wr_data !== mk_line(8'hF0)) begin failures++; $display("FAIL idchg_wr_data act=%h exp=%h", dat_ram_wr_data, mk_line(8'hF0)); end
    @(negedge clk);
    checks++; if (linefill_done_en !== 8'b0000_0100) begin failures++; $display("FAIL idchg_done act=%b exp=00000100", linefill_done_en); end
  endtask

  task automatic test_reset_mid_line();
    dat_ram_wr_rdy = 1'b1;
    send_beat(3'd3, mk_beat(8'h90, 0), 1'b0);
    send_beat(3'd3, mk_beat(8'h90, 1), 1'b0);
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_rdy !== 1'b1) begin failures++; $display("FAIL rstmid_rsp_rdy act=%b exp=1", rsp_rdy); end
    checks++; if (dat_ram_wr_vld !== 1'b0) begin failures++; $display("FAIL rstmid_wr_vld act=%b exp=0", dat_ram_wr_vld); end
    checks++; if (dat_ram_wr_id !== '0) begin failures++; $display("FAIL rstmid_wr_id act=%0d exp=0", dat_ram_wr_id); end
    checks++; if (dat_ram_wr_data !== '0) begin failures++; $display("FAIL rstmid_wr_data act=%h exp=0", dat_ram_wr_data); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL rstmid_proto_err act=%b exp=0", proto_err); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (linefill_done_en !== 8'b0) begin failures++; $display("FAIL rstmid_done c=%0d act=%b exp=0", c, linefill_done_en); end
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) send_beat(3'd0, mk_beat(8'h50, i), i == 3);
    checks++; if (dat_ram_wr_vld !== 1'b1) begin failures++; $display("FAIL rstmid_new_wr_vld act=%b exp=1", dat_ram_wr_vld); end
    checks++; if (dat_ram_wr_id !== 3'd0) begin failures++; $display("FAIL rstmid_new_wr_id act=%0d exp=0", dat_ram_wr_id); end
    checks++; if (dat_ram_wr_data !== mk_line(8'h50)) begin failures++; $display("FAIL rstmid_new_wr_data act=%h exp=%h", dat_ram_wr_data, mk_line(8'h50)); end
    @(negedge clk);
    checks++; if (linefill_done_en !== 8'b0000_0001) begin failures++; $display("FAIL rstmid_new_done act=%b exp=00000001", linefill_done_en); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL rstmid_new_proto_err act=%b exp=0", proto_err); end
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_backpressure();
    test_back_to_back();
    test_early_last();
    test_id_change();
    test_reset_mid_line();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
